mem_seq: RTL

Parametrised byte-serial memory sequencer that performs big-endian multi-byte loads and stores over the 8-bit memory port. It sits between the CPU core's execute stage and the byte-wide memory, and replaces the per-size hand-coded load/store states. It is generalised over word width and read latency, and adds an accept/response handshake, `mem_ready` wait states, sign extension and size-error reporting.

---
 rtl/mem_seq_pkg.sv | 17 +
 rtl/mem_seq_if.sv | 38 +++
 rtl/mem_seq_extend.sv | 26 ++
 rtl/mem_seq.sv | 128 ++++++++++++
 4 files changed

// File: rtl/mem_seq_pkg.sv
// Shared encodings for the byte-serial memory sequencer.
package mem_seq_pkg;

    // Transfer size encodings (log2 of byte count)
    localparam logic [2:0] SIZE_BYTE = 3'd0;
    localparam logic [2:0] SIZE_HALF = 3'd1;
    localparam logic [2:0] SIZE_WORD = 3'd2;

    // Sequencer state encodings
    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_RD_WAIT   = 3'd1;
    localparam logic [2:0] ST_RD_SAMPLE = 3'd2;
    localparam logic [2:0] ST_WR_SETUP  = 3'd3;
    localparam logic [2:0] ST_WR_STROBE = 3'd4;
    localparam logic [2:0] ST_DONE      = 3'd5;

endpackage

// File: rtl/mem_seq_if.sv
// Request/response handshake plus byte-wide memory port of the sequencer.
interface mem_seq_if #(
    parameter int ADDR_WIDTH = 9,
    parameter int WORD_BYTES = 4
);
    logic                      req_valid;
    logic                      req_ready;
    logic                      req_write;
    logic [2:0]                req_size;
    logic                      req_signed;
    logic [ADDR_WIDTH-1:0]     req_addr;
    logic [8*WORD_BYTES-1:0]   req_wdata;
    logic                      rsp_valid;
    logic                      rsp_err;
    logic [8*WORD_BYTES-1:0]   rsp_rdata;
    logic [ADDR_WIDTH-1:0]     mem_raddr;
    logic [7:0]                mem_data_out;
    logic [ADDR_WIDTH-1:0]     mem_waddr;
    logic [7:0]                mem_data_in;
    logic                      mem_write;
    logic                      mem_ready;

    // Environment view: execute stage plus memory
    modport master (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        output mem_data_out, mem_ready,
        input  req_ready, rsp_valid, rsp_err, rsp_rdata,
        input  mem_raddr, mem_waddr, mem_data_in, mem_write
    );

    // Sequencer view
    modport slave (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata,
        input  mem_data_out, mem_ready,
        output req_ready, rsp_valid, rsp_err, rsp_rdata,
        output mem_raddr, mem_waddr, mem_data_in, mem_write
    );
endinterface

// File: rtl/mem_seq_extend.sv
// Keeps the low N bytes of the load accumulator and sign/zero extends them.
module mem_seq_extend #(
    parameter int WORD_BYTES = 4
) (
    input  logic [8*WORD_BYTES-1:0] acc,
    input  logic [2:0]              size,
    input  logic                    sign_ext,
    output logic [8*WORD_BYTES-1:0] data
);
    int unsigned nb;
    logic        msb;

    // Slice N bytes and fill the upper bits with the extension bit
    always_comb begin
        nb   = 32'd1 << size;
        msb  = 1'b0;
        data = '0;
        for (int unsigned j = 0; j < WORD_BYTES; j++) begin
            if (j + 1 == nb) msb = acc[8*j+7];
        end
        for (int unsigned i = 0; i < 8*WORD_BYTES; i++) begin
            if (i < 8*nb) data[i] = acc[i];
            else          data[i] = sign_ext & msb;
        end
    end
endmodule

// File: rtl/mem_seq.sv
// Byte-serial big-endian load/store sequencer over an 8-bit memory port.
module mem_seq
    import mem_seq_pkg::*;
#(
    parameter int ADDR_WIDTH   = 9,
    parameter int WORD_BYTES   = 4,
    parameter int READ_LATENCY = 1
) (
    input  logic     clk,
    input  logic     reset,
    mem_seq_if.slave bus
);
    localparam int         DW       = 8*WORD_BYTES;
    localparam logic [2:0] SIZE_MAX = 3'($clog2(WORD_BYTES));
    localparam logic [2:0] RD_FIRST = (READ_LATENCY == 0) ? ST_RD_SAMPLE : ST_RD_WAIT;
    localparam logic [2:0] LAT_INIT = 3'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);

    logic [2:0]    state;
    logic [2:0]    wait_cnt;
    logic [3:0]    bytes_left;
    logic [2:0]    size_q;
    logic          signed_q;
    logic [DW-1:0] acc;
    logic [DW-1:0] acc_next;
    logic [DW-1:0] wbuf;
    logic [DW-1:0] wbuf_next;
    logic [DW-1:0] wdata_aligned;
    logic [DW-1:0] ext_data;
    logic          accept;
    logic          size_err;
    int unsigned   nbytes_req;

    assign bus.req_ready = (state == ST_IDLE) && !reset;
    assign bus.rsp_valid = (state == ST_DONE);
    assign bus.mem_write = (state == ST_WR_STROBE);

    assign accept    = bus.req_valid && bus.req_ready;
    assign size_err  = bus.req_size > SIZE_MAX;
    assign acc_next  = (acc << 8) | DW'(bus.mem_data_out);
    assign wbuf_next = wbuf << 8;

    // Left-align store data so the next byte to write is always the top byte
    always_comb begin
        nbytes_req    = 32'd1 << bus.req_size;
        wdata_aligned = bus.req_wdata << (8 * (WORD_BYTES - nbytes_req));
    end

    mem_seq_extend #(.WORD_BYTES(WORD_BYTES)) u_extend (
        .acc      (acc_next),
        .size     (size_q),
        .sign_ext (signed_q),
        .data     (ext_data)
    );

    // Transfer sequencing, address stepping and response capture
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= ST_IDLE;
            wait_cnt        <= '0;
            bytes_left      <= '0;
            size_q          <= '0;
            signed_q        <= 1'b0;
            acc             <= '0;
            wbuf            <= '0;
            bus.rsp_err     <= 1'b0;
            bus.rsp_rdata   <= '0;
            bus.mem_raddr   <= '0;
            bus.mem_waddr   <= '0;
            bus.mem_data_in <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        size_q        <= bus.req_size;
                        signed_q      <= bus.req_signed;
                        acc           <= '0;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_rdata <= '0;
                        bytes_left    <= nbytes_req[3:0];
                        if (size_err) begin
                            bus.rsp_err <= 1'b1;
                            state       <= ST_DONE;
                        end else if (bus.req_write) begin
                            bus.mem_waddr   <= bus.req_addr;
                            wbuf            <= wdata_aligned;
                            bus.mem_data_in <= wdata_aligned[DW-1 -: 8];
                            state           <= ST_WR_SETUP;
                        end else begin
                            bus.mem_raddr <= bus.req_addr;
                            wait_cnt      <= LAT_INIT;
                            state         <= RD_FIRST;
                        end
                    end
                end
                ST_RD_WAIT: begin
                    if (wait_cnt == 3'd0) state <= ST_RD_SAMPLE;
                    else                  wait_cnt <= wait_cnt - 3'd1;
                end
                ST_RD_SAMPLE: begin
                    if (bus.mem_ready) begin
                        acc           <= acc_next;
                        bus.mem_raddr <= bus.mem_raddr + ADDR_WIDTH'(1);
                        bytes_left    <= bytes_left - 4'd1;
                        wait_cnt      <= LAT_INIT;
                        if (bytes_left == 4'd1) begin
                            bus.rsp_rdata <= ext_data;
                            state         <= ST_DONE;
                        end else begin
                            state <= RD_FIRST;
                        end
                    end
                end
                ST_WR_SETUP: state <= ST_WR_STROBE;
                ST_WR_STROBE: begin
                    if (bus.mem_ready) begin
                        bus.mem_waddr   <= bus.mem_waddr + ADDR_WIDTH'(1);
                        wbuf            <= wbuf_next;
                        bus.mem_data_in <= wbuf_next[DW-1 -: 8];
                        bytes_left      <= bytes_left - 4'd1;
                        state           <= (bytes_left == 4'd1) ? ST_DONE : ST_WR_SETUP;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
